// File: rtl/aes_key_expander.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_key_expander: iterative AES-128 key schedule, one word (w4..w43)/clock |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_key_expander (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic [127:0]        key_in,
   output logic [0:43][31:0]   key_schedule,
   output logic                busy,
   output logic                key_valid
);

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_expand = 2'd1;
   localparam logic [1:0] c_st_done   = 2'd2;

   localparam logic [0:255][7:0] c_sbox = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   logic [1:0]         state_q, state_d;
   logic [5:0]         cnt_q, cnt_d;
   logic [0:43][31:0]  sched_q, sched_d;
   logic               busy_q, busy_d;
   logic               valid_q, valid_d;

   logic [31:0] w_prev, w_back, w_rot, w_sub, w_temp;

   always_comb begin
      w_prev = sched_q[cnt_q - 6'd1];
      w_back = sched_q[cnt_q - 6'd4];
      w_rot  = {w_prev[23:0], w_prev[31:24]};
      w_sub  = {c_sbox[w_rot[31:24]], c_sbox[w_rot[23:16]],
                c_sbox[w_rot[15:8]],  c_sbox[w_rot[7:0]]};
      // Every fourth word starts a new round key and takes the non-linear path.
      w_temp = (cnt_q[1:0] == 2'b00) ? (w_sub ^ {rcon(cnt_q[5:2]), 24'h0}) : w_prev;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sched_d = sched_q;
      busy_d  = busy_q;
      valid_d = valid_q;
      case (state_q)
         c_st_idle, c_st_done: begin
            if (start) begin
               sched_d[0] = key_in[127:96];
               sched_d[1] = key_in[95:64];
               sched_d[2] = key_in[63:32];
               sched_d[3] = key_in[31:0];
               cnt_d      = 6'd4;
               busy_d     = 1'b1;
               valid_d    = 1'b0;
               state_d    = c_st_expand;
            end
         end
         c_st_expand: begin
            sched_d[cnt_q] = w_back ^ w_temp;
            cnt_d          = cnt_q + 6'd1;
            if (cnt_q == 6'd43) begin
               state_d = c_st_done;
               busy_d  = 1'b0;
               valid_d = 1'b1;
            end
         end
         default: state_d = c_st_idle;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= c_st_idle;
         cnt_q   <= 6'd0;
         sched_q <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sched_q <= sched_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign key_schedule = sched_q;
   assign busy         = busy_q;
   assign key_valid    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expander.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aes_key_expander: directed FIPS-197 vectors for aes_key_expander        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_aes_key_expander;

   localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_ZERO = 128'h0;
   localparam logic [31:0] A1_MID   [4] = '{32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605};
   localparam logic [31:0] A1_LAST  [4] = '{32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6};
   localparam logic [31:0] Z_MID    [4] = '{32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363};
   localparam logic [31:0] Z_LAST   [4] = '{32'hb4ef5bcb, 32'h3e92e211, 32'h23e951cf, 32'h6f8f188e};

   logic               clk = 1'b0;
   logic               n_rst = 1'b0;
   logic               start = 1'b0;
   logic [127:0]       key_in = '0;
   logic [0:43][31:0]  key_schedule;
   logic               busy;
   logic               key_valid;

   int n_checks = 0;
   int n_fail   = 0;

   aes_key_expander dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .start        (start),
      .key_in       (key_in),
      .key_schedule (key_schedule),
      .busy         (busy),
      .key_valid    (key_valid)
   );

   always #5 clk = ~clk;

   // Pulse start for one edge; returns at the negedge after the accept edge.
   task automatic pulse_start(input logic [127:0] k);
      @(negedge clk);
      key_in = k;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Counts sampled cycles with busy high, bounded.
   task automatic wait_done(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      n_checks++;
      if (key_schedule !== '0 || busy !== 1'b0 || key_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b valid=%b w0=%h (want 0,0,0)", busy, key_valid, key_schedule[0]);
      end
   endtask

   task automatic test_a1;
      int n;
      pulse_start(KEY_A1);
      n_checks++;
      if (busy !== 1'b1 || key_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL a1_accept: busy=%b valid=%b (want 1,0)", busy, key_valid);
      end
      wait_done(n);
      n_checks++;
      if (n != 40 || key_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL a1_latency: busy_cycles=%0d valid=%b (want 40,1)", n, key_valid);
      end
      n_checks++;
      if ({key_schedule[0], key_schedule[1], key_schedule[2], key_schedule[3]} !== KEY_A1) begin
         n_fail++;
         $display("FAIL a1_w0_3: got %h %h %h %h", key_schedule[0], key_schedule[1], key_schedule[2], key_schedule[3]);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (key_schedule[4+i] !== A1_MID[i]) begin
            n_fail++;
            $display("FAIL a1_w%0d: got %h want %h", 4+i, key_schedule[4+i], A1_MID[i]);
         end
         n_checks++;
         if (key_schedule[40+i] !== A1_LAST[i]) begin
            n_fail++;
            $display("FAIL a1_w%0d: got %h want %h", 40+i, key_schedule[40+i], A1_LAST[i]);
         end
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (key_valid !== 1'b1 || busy !== 1'b0 || key_schedule[43] !== A1_LAST[3]) begin
         n_fail++;
         $display("FAIL a1_hold: valid=%b busy=%b w43=%h", key_valid, busy, key_schedule[43]);
      end
   endtask

   task automatic test_back_to_back;
      int n;
      pulse_start(KEY_ZERO);
      n_checks++;
      if (key_valid !== 1'b0 || busy !== 1'b1 || key_schedule[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL b2b_accept: valid=%b busy=%b w0=%h (want 0,1,0)", key_valid, busy, key_schedule[0]);
      end
      wait_done(n);
      n_checks++;
      if (n != 40 || key_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_latency: busy_cycles=%0d valid=%b (want 40,1)", n, key_valid);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (key_schedule[4+i] !== Z_MID[i] || key_schedule[40+i] !== Z_LAST[i]) begin
            n_fail++;
            $display("FAIL zero_w%0d/w%0d: got %h %h want %h %h", 4+i, 40+i,
                     key_schedule[4+i], key_schedule[40+i], Z_MID[i], Z_LAST[i]);
         end
      end
   endtask

   task automatic test_start_held;
      int early_valid = 0;
      int n;
      @(negedge clk);
      key_in = KEY_A1;
      start  = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c == 5) key_in = KEY_ZERO;
         if (key_valid) early_valid++;
      end
      @(negedge clk);  // after edge 40
      n_checks++;
      if (early_valid != 0 || key_valid !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL held_valid: early=%0d valid=%b busy=%b (want 0,1,0)", early_valid, key_valid, busy);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (key_schedule[40+i] !== A1_LAST[i]) begin
            n_fail++;
            $display("FAIL held_w%0d: got %h want %h", 40+i, key_schedule[40+i], A1_LAST[i]);
         end
      end
      @(negedge clk);  // edge 41 re-accepts with the zero key
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || key_valid !== 1'b0 || key_schedule[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL held_restart: busy=%b valid=%b w0=%h (want 1,0,0)", busy, key_valid, key_schedule[0]);
      end
      wait_done(n);
      n_checks++;
      if (n != 40 || key_schedule[43] !== Z_LAST[3]) begin
         n_fail++;
         $display("FAIL held_second: busy_cycles=%0d w43=%h want 40 %h", n, key_schedule[43], Z_LAST[3]);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      pulse_start(KEY_A1);
      repeat (19) @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      n_checks++;
      if (key_schedule !== '0 || busy !== 1'b0 || key_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%b valid=%b w0=%h w4=%h (want all 0)", busy, key_valid,
                  key_schedule[0], key_schedule[4]);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || key_schedule[4] !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_hold: busy=%b w4=%h (want 0,0)", busy, key_schedule[4]);
      end
      n_rst = 1'b1;
      pulse_start(KEY_ZERO);
      wait_done(n);
      n_checks++;
      if (n != 40 || key_valid !== 1'b1 || key_schedule[4] !== Z_MID[0] || key_schedule[43] !== Z_LAST[3]) begin
         n_fail++;
         $display("FAIL reset_then_zero: cycles=%0d valid=%b w4=%h w43=%h", n, key_valid,
                  key_schedule[4], key_schedule[43]);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset;
      n_rst = 1'b1;
      test_a1;
      test_back_to_back;
      test_start_held;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Iterative AES-128 key expansion unit that produces the 44-word key schedule consumed by the encryption and decryption round pipelines.
- It accepts one 128-bit cipher key on a start pulse and computes one schedule word per clock.
- It holds the completed schedule stable with key_valid asserted until the next start.
- It sits directly upstream of the decryption pipeline's key_schedule input.

Parameters:
- None. The schedule length is fixed at 44 words, 32 bits each (AES-128, Nk=4, Nr=10).

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to expand key_in; ignored while busy
- key_in  input  128  cipher key; key_in[127:96] is w0, key_in[31:0] is w3; sampled only on an accepted start
- key_schedule  output  [0:43][31:0]  registered schedule words w0..w43, index 0 = w0
- busy  output  1  high while expansion is in progress
- key_valid  output  1  high when key_schedule holds a complete, stable schedule for the last accepted key

Behaviour:
- Reset (n_rst low, asynchronous):
  - State goes to IDLE.
  - All 44 key_schedule words are 0.
  - busy=0, key_valid=0, word counter=0.
  - Reset asserted mid-expansion aborts it immediately; no partial schedule survives.
- States: IDLE, EXPAND, DONE.
- IDLE or DONE with start=1 at a rising edge (the accept edge):
  - Load w0..w3 from key_in.
  - Counter := 4, busy := 1, key_valid := 0, state := EXPAND.
  - Words w4..w43 keep their old values until overwritten.
- IDLE or DONE with start=0: hold everything.
- EXPAND, at each edge, with i = counter:
  - temp = w[i-1].
  - If i mod 4 == 0: temp = SubWord(RotWord(temp)) xor {Rcon[i/4], 24'h0}.
  - w[i] := w[i-4] xor temp; counter := i+1.
- RotWord({a,b,c,d}) = {b,c,d,a}. SubWord applies the FIPS-197 forward S-box to each byte. The S-box is a 256-entry combinational table inside this block.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. All arithmetic is bitwise XOR; no carries.
- When i == 43 is written: state := DONE, busy := 0, key_valid := 1 on that same edge.
- Latency: the accept edge is edge 0. w4 is written at edge 1, w43 at edge 40. key_valid is first visible high after edge 40. busy is high for exactly 40 cycles.
- start while in EXPAND is ignored: no restart, no queuing, key_in is not resampled.
- start in DONE restarts expansion; key_valid drops at the accept edge.
- key_in changes outside the accept edge have no effect.
- Outputs are registers only; no combinational path from inputs to outputs.
- Downstream consumers must use key_schedule only while key_valid=1.

Test Plan:
- FIPS-197 A.1 key: key_in=2b7e151628aed2a6abf7158809cf4f3c, pulse start.
  - busy high for 40 cycles, then key_valid=1.
  - w4=a0fafe17, w40..w43 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- All-zero key, start:
  - w4=62636363.
  - w40..w43 = b4ef5bcb 3e92e211 23e951cf 6f8f188e.
- Start held high continuously from the accept edge through EXPAND, with key_in changed to all-zero at cycle 5:
  - Result equals the A.1 schedule.
  - key_valid rises once after 40 cycles.
  - A new expansion begins on the first edge in DONE where start is still high.
- Reset pulse at cycle 20 of an A.1 expansion:
  - All outputs immediately 0, state IDLE.
  - A subsequent zero-key start produces the correct zero-key schedule.
- Back-to-back: complete A.1, then start with the zero key in DONE.
  - key_valid goes 1→0 at the accept edge and returns to 1 after 40 cycles with the zero-key values.
- Integration with the decryption pipeline: A.1 schedule, d_in=3925841d02dc09fbdc118597196a0b32.
  - Pipeline output is 3243f6a8885a308d313198a2e0370734 after its fixed latency.
